// File: rtl/keypad_entry.sv
// ============================================================================
//  Module      : keypad_entry
//  Description : 4x4 matrix keypad scanner with press/release debounce that
//                assembles two hex digits into the 8-bit Result operand.
//                Define KEYPAD_BCD_ONLY_EN for decimal entry with a clear key.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_entry #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       CLK,
  input  logic       Reset_n,
  input  logic [3:0] Row,
  output logic [3:0] Col,
  output logic [7:0] Result,
  output logic [3:0] Key_Code,
  output logic       Key_Valid,
  output logic       Entry_Done
);

  localparam int c_tick_w = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int c_db_w   = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(SCAN_DIV - 1);
  localparam logic [c_db_w-1:0]   c_db_last   = c_db_w'(DEBOUNCE_SCANS - 1);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HOLD     = 2'd2
  } state_t;

  generate
    if (SCAN_DIV < 4) begin : g_bad_scan_div
      $error("keypad_entry: SCAN_DIV must be at least 4");
    end
    if (DEBOUNCE_SCANS < 2) begin : g_bad_debounce
      $error("keypad_entry: DEBOUNCE_SCANS must be at least 2");
    end
  endgenerate

  logic [3:0]          r_row_meta;
  logic [3:0]          r_row_sync;
  logic [c_tick_w-1:0] r_tick_cnt;
  logic                w_tick;

  state_t              r_state;
  logic [1:0]          r_col_idx;
  logic [1:0]          r_row_lat;
  logic [c_db_w-1:0]   r_db_cnt;
  logic [c_db_w-1:0]   r_rel_cnt;
  logic [1:0]          r_digit_cnt;

  logic                w_row_low;
  logic [1:0]          w_row_idx;
  logic [1:0]          w_col_adv;
  logic [3:0]          w_code;
  logic                w_is_digit;
  logic                w_is_clear;
  logic [7:0]          w_result_next;
  logic [1:0]          w_digit_next;
  logic                w_done_next;

  // Rows idle high, so the synchronizer resets to all-ones.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      r_row_meta <= 4'hF;
      r_row_sync <= 4'hF;
    end else begin
      r_row_meta <= Row;
      r_row_sync <= r_row_meta;
    end
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      r_tick_cnt <= '0;
    end else if (r_tick_cnt == c_tick_last) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  assign w_tick = (r_tick_cnt == c_tick_last);

  // Descending loop so the lowest low row is the last assignment and wins.
  always_comb begin
    w_row_low = 1'b0;
    w_row_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!r_row_sync[i]) begin
        w_row_low = 1'b1;
        w_row_idx = 2'(i);
      end
    end
  end

  assign w_col_adv = r_col_idx + 2'd1;
  assign w_code    = {r_row_lat, r_col_idx};

`ifdef KEYPAD_BCD_ONLY_EN
  assign w_is_digit = (w_code <= 4'd9);
  assign w_is_clear = (w_code == 4'hA);
`else
  assign w_is_digit = 1'b1;
  assign w_is_clear = 1'b0;
`endif

  always_comb begin
    w_result_next = Result;
    w_digit_next  = r_digit_cnt;
    w_done_next   = 1'b0;
    if (w_is_clear) begin
      w_result_next = 8'h00;
      w_digit_next  = 2'd0;
    end else if (w_is_digit) begin
      if (r_digit_cnt == 2'd1) begin
        w_result_next = {Result[3:0], w_code};
        w_digit_next  = 2'd2;
        w_done_next   = 1'b1;
      end else begin
        w_result_next = {4'h0, w_code};
        w_digit_next  = 2'd1;
      end
    end
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state     <= ST_SCAN;
      r_col_idx   <= 2'd0;
      Col         <= 4'b1110;
      r_row_lat   <= 2'd0;
      r_db_cnt    <= '0;
      r_rel_cnt   <= '0;
      r_digit_cnt <= 2'd0;
      Result      <= 8'h00;
      Key_Code    <= 4'h0;
      Key_Valid   <= 1'b0;
      Entry_Done  <= 1'b0;
    end else begin
      Key_Valid  <= 1'b0;
      Entry_Done <= 1'b0;
      if (w_tick) begin
        case (r_state)
          ST_SCAN: begin
            if (w_row_low) begin
              r_row_lat <= w_row_idx;
              r_db_cnt  <= c_db_w'(1);
              r_state   <= ST_DEBOUNCE;
            end else begin
              r_col_idx <= w_col_adv;
              Col       <= ~(4'b0001 << w_col_adv);
            end
          end
          ST_DEBOUNCE: begin
            if (w_row_low && (w_row_idx == r_row_lat)) begin
              if (r_db_cnt == c_db_last) begin
                Key_Code    <= w_code;
                Key_Valid   <= 1'b1;
                Result      <= w_result_next;
                r_digit_cnt <= w_digit_next;
                Entry_Done  <= w_done_next;
                r_rel_cnt   <= '0;
                r_state     <= ST_HOLD;
              end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
              end
            end else begin
              r_col_idx <= w_col_adv;
              Col       <= ~(4'b0001 << w_col_adv);
              r_state   <= ST_SCAN;
            end
          end
          ST_HOLD: begin
            if (w_row_low) begin
              r_rel_cnt <= '0;
            end else if (r_rel_cnt == c_db_last) begin
              r_col_idx <= 2'd0;
              Col       <= 4'b1110;
              r_state   <= ST_SCAN;
            end else begin
              r_rel_cnt <= r_rel_cnt + 1'b1;
            end
          end
          default: begin
            r_col_idx <= 2'd0;
            Col       <= 4'b1110;
            r_state   <= ST_SCAN;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_keypad_entry.sv
// ============================================================================
//  Module      : tb_keypad_entry
//  Description : Directed self-checking bench for keypad_entry with a
//                behavioural 4x4 key matrix (SCAN_DIV=4, DEBOUNCE_SCANS=2).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_keypad_entry;

  logic       CLK;
  logic       Reset_n;
  logic [3:0] Row;
  logic [3:0] Col;
  logic [7:0] Result;
  logic [3:0] Key_Code;
  logic       Key_Valid;
  logic       Entry_Done;

  logic [15:0] pressed;
  logic        ovr_en;
  logic [3:0]  ovr_val;

  int errors;
  int checks;
  int valid_cnt;

  keypad_entry #(
    .SCAN_DIV       (4),
    .DEBOUNCE_SCANS (2)
  ) dut (
    .CLK        (CLK),
    .Reset_n    (Reset_n),
    .Row        (Row),
    .Col        (Col),
    .Result     (Result),
    .Key_Code   (Key_Code),
    .Key_Valid  (Key_Valid),
    .Entry_Done (Entry_Done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // A pressed key pulls its row low only while its column is driven.
  always_comb begin
    Row = 4'hF;
    if (ovr_en) begin
      Row = ovr_val;
    end else begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          if (pressed[r*4+c] && !Col[c]) Row[r] = 1'b0;
    end
  end

  always @(negedge CLK) if (Key_Valid === 1'b1) valid_cnt++;

  task automatic wait_valid(input int max_cycles, output bit found);
    found = 1'b0;
    for (int i = 0; i < max_cycles && !found; i++) begin
      @(negedge CLK);
      if (Key_Valid === 1'b1) found = 1'b1;
    end
  endtask

  task automatic press_key(input int code, output bit found);
    pressed[code] = 1'b1;
    wait_valid(200, found);
  endtask

  task automatic release_keys();
    pressed = 16'h0;
    repeat (40) @(negedge CLK);
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    repeat (3) @(negedge CLK);
    checks++; if (Col !== 4'b1110) begin errors++; $display("FAIL reset_col got=%b exp=1110", Col); end
    checks++; if (Result !== 8'h00) begin errors++; $display("FAIL reset_result got=%h exp=00", Result); end
    checks++; if (Key_Code !== 4'h0) begin errors++; $display("FAIL reset_code got=%h exp=0", Key_Code); end
    checks++; if (Key_Valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", Key_Valid); end
    checks++; if (Entry_Done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", Entry_Done); end
    Reset_n = 1'b1;
    repeat (5) @(negedge CLK);
  endtask

  task automatic test_two_digits();
    bit f;
    press_key(6, f);
    checks++; if (!f) begin errors++; $display("FAIL key6_timeout got=none exp=Key_Valid"); end
    checks++; if (Key_Code !== 4'h6) begin errors++; $display("FAIL key6_code got=%h exp=6", Key_Code); end
    checks++; if (Result !== 8'h06) begin errors++; $display("FAIL key6_result got=%h exp=06", Result); end
    checks++; if (Entry_Done !== 1'b0) begin errors++; $display("FAIL key6_done got=%b exp=0", Entry_Done); end
    @(negedge CLK);
    checks++; if (Key_Valid !== 1'b0) begin errors++; $display("FAIL key6_pulse_width got=%b exp=0", Key_Valid); end
    release_keys();
    press_key(11, f);
    checks++; if (!f) begin errors++; $display("FAIL keyB_timeout got=none exp=Key_Valid"); end
    checks++; if (Result !== 8'h6B) begin errors++; $display("FAIL keyB_result got=%h exp=6B", Result); end
    checks++; if (Entry_Done !== 1'b1) begin errors++; $display("FAIL keyB_done got=%b exp=1", Entry_Done); end
    @(negedge CLK);
    checks++; if (Entry_Done !== 1'b0) begin errors++; $display("FAIL keyB_done_width got=%b exp=0", Entry_Done); end
    release_keys();
  endtask

  task automatic test_third_digit();
    bit f;
    press_key(3, f);
    checks++; if (!f) begin errors++; $display("FAIL key3_timeout got=none exp=Key_Valid"); end
    checks++; if (Result !== 8'h03) begin errors++; $display("FAIL key3_result got=%h exp=03", Result); end
    checks++; if (Entry_Done !== 1'b0) begin errors++; $display("FAIL key3_done got=%b exp=0", Entry_Done); end
    release_keys();
    pressed[13] = 1'b1;
    press_key(5, f);
    checks++; if (!f) begin errors++; $display("FAIL multirow_timeout got=none exp=Key_Valid"); end
    checks++; if (Key_Code !== 4'h5) begin errors++; $display("FAIL multirow_code got=%h exp=5", Key_Code); end
    checks++; if (Result !== 8'h35) begin errors++; $display("FAIL multirow_result got=%h exp=35", Result); end
    release_keys();
  endtask

  task automatic test_bounce();
    int         v0;
    bit         seen;
    logic [3:0] prev;
    logic [3:0] c0;
    v0   = valid_cnt;
    seen = 1'b0;
    @(negedge CLK);
    prev = Col;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge CLK);
      if (Col !== prev) seen = 1'b1;
      prev = Col;
    end
    checks++; if (!seen) begin errors++; $display("FAIL bounce_scan_timeout got=%b exp=changing", Col); end
    c0 = Col;
    @(negedge CLK);
    ovr_val = 4'b1101;
    ovr_en  = 1'b1;
    repeat (4) @(negedge CLK);
    ovr_en  = 1'b0;
    checks++; if (Col !== c0) begin errors++; $display("FAIL bounce_col_hold got=%b exp=%b", Col, c0); end
    repeat (3) @(negedge CLK);
    checks++; if (Col !== {c0[2:0], c0[3]}) begin errors++; $display("FAIL bounce_col_adv got=%b exp=%b", Col, {c0[2:0], c0[3]}); end
    repeat (20) @(negedge CLK);
    checks++; if (valid_cnt !== v0) begin errors++; $display("FAIL bounce_no_valid got=%0d exp=%0d", valid_cnt, v0); end
  endtask

  task automatic test_long_hold();
    int v0;
    bit f;
    v0 = valid_cnt;
    pressed[0] = 1'b1;
    repeat (2000) @(negedge CLK);
    checks++; if (valid_cnt !== v0 + 1) begin errors++; $display("FAIL hold_single got=%0d exp=%0d", valid_cnt, v0 + 1); end
    checks++; if (Key_Code !== 4'h0) begin errors++; $display("FAIL hold_code got=%h exp=0", Key_Code); end
    checks++; if (Result !== 8'h00) begin errors++; $display("FAIL hold_result got=%h exp=00", Result); end
    release_keys();
    press_key(0, f);
    checks++; if (!f) begin errors++; $display("FAIL repress_timeout got=none exp=Key_Valid"); end
    repeat (100) @(negedge CLK);
    checks++; if (valid_cnt !== v0 + 2) begin errors++; $display("FAIL repress_count got=%0d exp=%0d", valid_cnt, v0 + 2); end
    release_keys();
  endtask

  task automatic test_reset_mid_hold();
    int v0;
    bit f;
    press_key(9, f);
    checks++; if (!f) begin errors++; $display("FAIL key9_timeout got=none exp=Key_Valid"); end
    checks++; if (Result !== 8'h09) begin errors++; $display("FAIL key9_result got=%h exp=09", Result); end
    repeat (10) @(negedge CLK);
    #2 Reset_n = 1'b0;
    #1;
    checks++; if (Col !== 4'b1110) begin errors++; $display("FAIL midrst_col got=%b exp=1110", Col); end
    checks++; if (Result !== 8'h00) begin errors++; $display("FAIL midrst_result got=%h exp=00", Result); end
    checks++; if (Key_Code !== 4'h0) begin errors++; $display("FAIL midrst_code got=%h exp=0", Key_Code); end
    checks++; if (Key_Valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b exp=0", Key_Valid); end
    repeat (3) @(negedge CLK);
    Reset_n = 1'b1;
    v0 = valid_cnt;
    wait_valid(200, f);
    checks++; if (!f) begin errors++; $display("FAIL redetect_timeout got=none exp=Key_Valid"); end
    checks++; if (Key_Code !== 4'h9) begin errors++; $display("FAIL redetect_code got=%h exp=9", Key_Code); end
    checks++; if (Result !== 8'h09) begin errors++; $display("FAIL redetect_result got=%h exp=09", Result); end
    repeat (200) @(negedge CLK);
    checks++; if (valid_cnt !== v0 + 1) begin errors++; $display("FAIL redetect_count got=%0d exp=%0d", valid_cnt, v0 + 1); end
    release_keys();
  endtask

`ifdef KEYPAD_BCD_ONLY_EN
  task automatic test_bcd();
    bit f;
    press_key(6, f); release_keys();
    press_key(6, f);
    checks++; if (Result !== 8'h06) begin errors++; $display("FAIL bcd_pre_result got=%h exp=06", Result); end
    release_keys();
    press_key(10, f);
    checks++; if (!f) begin errors++; $display("FAIL bcd_clear_timeout got=none exp=Key_Valid"); end
    checks++; if (Result !== 8'h00) begin errors++; $display("FAIL bcd_clear_result got=%h exp=00", Result); end
    checks++; if (Key_Code !== 4'hA) begin errors++; $display("FAIL bcd_clear_code got=%h exp=A", Key_Code); end
    checks++; if (Entry_Done !== 1'b0) begin errors++; $display("FAIL bcd_clear_done got=%b exp=0", Entry_Done); end
    release_keys();
    press_key(12, f);
    checks++; if (!f) begin errors++; $display("FAIL bcd_C_timeout got=none exp=Key_Valid"); end
    checks++; if (Key_Code !== 4'hC) begin errors++; $display("FAIL bcd_C_code got=%h exp=C", Key_Code); end
    checks++; if (Result !== 8'h00) begin errors++; $display("FAIL bcd_C_result got=%h exp=00", Result); end
    release_keys();
    press_key(7, f);
    checks++; if (Result !== 8'h07) begin errors++; $display("FAIL bcd_after_clear got=%h exp=07", Result); end
    release_keys();
  endtask
`else
  task automatic test_hex();
    bit f;
    press_key(10, f);
    checks++; if (!f) begin errors++; $display("FAIL hexA_timeout got=none exp=Key_Valid"); end
    checks++; if (Result !== 8'h9A) begin errors++; $display("FAIL hexA_result got=%h exp=9A", Result); end
    checks++; if (Entry_Done !== 1'b1) begin errors++; $display("FAIL hexA_done got=%b exp=1", Entry_Done); end
    release_keys();
    press_key(12, f);
    checks++; if (Result !== 8'h0C) begin errors++; $display("FAIL hexC_result got=%h exp=0C", Result); end
    checks++; if (Entry_Done !== 1'b0) begin errors++; $display("FAIL hexC_done got=%b exp=0", Entry_Done); end
    release_keys();
  endtask
`endif

  initial begin
    errors    = 0;
    checks    = 0;
    valid_cnt = 0;
    pressed   = 16'h0;
    ovr_en    = 1'b0;
    ovr_val   = 4'hF;
    Reset_n   = 1'b0;
    test_reset();
    test_two_digits();
    test_third_digit();
    test_bounce();
    test_long_hold();
    test_reset_mid_hold();
`ifdef KEYPAD_BCD_ONLY_EN
    test_bcd();
`else
    test_hex();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
